// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES S-box tables, SubBytes FSM state type and lookup helper.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_bytes_state_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    return inv ? SBOX_INV[b] : SBOX_FWD[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// rtl/sbox_lane.sv - one combinational S-box byte lane; inverse table only with SUB_BYTES_INV_EN.
module sbox_lane (
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte
);
  import aes_pkg::*;

`ifdef SUB_BYTES_INV_EN
  assign o_byte = sbox_lookup(i_byte, i_inv);
`else
  // Encrypt-only build: mode input is intentionally ignored.
  logic unused_inv;
  assign unused_inv = i_inv;
  assign o_byte     = SBOX_FWD[i_byte];
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - multi-cycle AES SubBytes engine, NUM_SBOX bytes per cycle; inverse mode with SUB_BYTES_INV_EN.
module sub_bytes_engine #(
  parameter int DATA_BYTES = 16,
  parameter int NUM_SBOX   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [8*DATA_BYTES-1:0] i_data,
  input  logic                    i_inv,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [8*DATA_BYTES-1:0] o_data,
  output logic                    o_busy
);
  import aes_pkg::*;

  localparam int NS_SAFE = (NUM_SBOX < 1) ? 1 : NUM_SBOX;
  localparam int K       = DATA_BYTES / NS_SAFE;
  localparam int CW      = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  if (NUM_SBOX < 1 || NUM_SBOX > DATA_BYTES || (DATA_BYTES % NS_SAFE) != 0) begin : g_bad_params
    $fatal(1, "sub_bytes_engine: DATA_BYTES must be a nonzero multiple of NUM_SBOX");
  end

  sub_bytes_state_e        state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [8*DATA_BYTES-1:0] work, work_nxt;
  logic                    mode, inv_sel, accept, last_chunk;
  logic [31:0]             base;
  logic [7:0]              lane_in  [NUM_SBOX];
  logic [7:0]              lane_out [NUM_SBOX];

`ifdef SUB_BYTES_INV_EN
  assign inv_sel = i_inv;
`else
  logic unused_i_inv;
  assign unused_i_inv = i_inv;
  assign inv_sel      = 1'b0;
`endif

  assign accept     = i_valid && o_ready;
  assign last_chunk = (cnt == LAST);
  assign base       = 32'(cnt) * 32'(NUM_SBOX);

  // Each lane reads its byte of the current chunk; results are written back in place.
  for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
    assign lane_in[l] = work[(base + 32'(l)) * 8 +: 8];
    sbox_lane u_lane (
      .i_byte (lane_in[l]),
      .i_inv  (mode),
      .o_byte (lane_out[l])
    );
  end

  always_comb begin
    work_nxt = work;
    for (int l = 0; l < NUM_SBOX; l++) begin
      work_nxt[(base + 32'(l)) * 8 +: 8] = lane_out[l];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_valid) state_nxt = BUSY;
      BUSY:    if (last_chunk) state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = i_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    unique case (state)
      IDLE:    o_ready = 1'b1;
      BUSY:    o_busy  = 1'b1;
      DONE:    begin
        o_valid = 1'b1;
        o_ready = i_ready;
      end
      default: o_ready = 1'b0;
    endcase
  end

  // o_data only updates when a word completes, so it holds its value while the next word is in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      work   <= '0;
      mode   <= 1'b0;
      cnt    <= '0;
      o_data <= '0;
    end else if (accept) begin
      work <= i_data;
      mode <= inv_sel;
      cnt  <= '0;
    end else if (state == BUSY) begin
      work <= work_nxt;
      cnt  <= last_chunk ? '0 : cnt + 1'b1;
      if (last_chunk) o_data <= work_nxt;
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb/tb_sub_bytes_engine.sv - bench for sub_bytes_engine at NUM_SBOX 1/4/16 against a GF(2^8) reference model.
module tb_sub_bytes_engine;
  import aes_pkg::*;

  localparam logic [127:0] VEC_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_S = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         v_i [3];
  logic         inv_i [3];
  logic         rdy_i [3];
  logic [127:0] d_i [3];
  logic         rdy_o [3];
  logic         v_o [3];
  logic         busy_o [3];
  logic [127:0] d_o [3];

  int   checks = 0;
  int   failures = 0;
  bit   inv_en;
  int   lat_of [3] = '{16, 4, 1};
  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sub_bytes_engine #(
      .DATA_BYTES (16),
      .NUM_SBOX   ((g == 0) ? 1 : ((g == 1) ? 4 : 16))
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (v_i[g]),
      .o_ready (rdy_o[g]),
      .i_data  (d_i[g]),
      .i_inv   (inv_i[g]),
      .o_valid (v_o[g]),
      .i_ready (rdy_i[g]),
      .o_data  (d_o[g]),
      .o_busy  (busy_o[g])
    );
  end

  // Reference S-box: multiplicative inverse in GF(2^8) followed by the AES affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int x = 1; x < 256; x++) if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [127:0] model_word(input logic [127:0] w, input logic inv);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = (inv && inv_en) ? m_inv[w[8*n +: 8]] : m_fwd[w[8*n +: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int idx, output int lat);
    lat = 0;
    while (!v_o[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One complete transaction with downstream always ready; latency counted from the accept edge.
  task automatic run(input int idx, input logic [127:0] d, input logic inv,
                     output int lat, output logic [127:0] res);
    int n = 0;
    @(negedge clk);
    d_i[idx] = d; inv_i[idx] = inv; v_i[idx] = 1'b1; rdy_i[idx] = 1'b1;
    while (!rdy_o[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 128'(n >= 50), 0);
    @(posedge clk);
    @(negedge clk);
    v_i[idx] = 1'b0; d_i[idx] = {$urandom, $urandom, $urandom, $urandom}; inv_i[idx] = ~inv;
    wait_valid(idx, lat);
    res = d_o[idx];
  endtask

  typedef struct {
    int           idx;
    logic [127:0] d;
    logic         inv;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  initial begin
    vec_t         vt [5];
    int           lat;
    logic [127:0] res, res2, w, held;

`ifdef SUB_BYTES_INV_EN
    inv_en = 1'b1;
`else
    inv_en = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      v_i[i] = 1'b0; inv_i[i] = 1'b0; rdy_i[i] = 1'b0; d_i[i] = '0;
    end
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      b = ginv(8'(x));
      m_fwd[x] = b ^ rol(b, 1) ^ rol(b, 2) ^ rol(b, 3) ^ rol(b, 4) ^ 8'h63;
      m_inv[m_fwd[x]] = 8'(x);
    end

    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_ready", i), rdy_o[i], 1);
      chk($sformatf("rst%0d_valid", i), v_o[i], 0);
      chk($sformatf("rst%0d_busy", i), busy_o[i], 0);
      chk($sformatf("rst%0d_data", i), d_o[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int x = 0; x < 256; x++) begin
      chk($sformatf("pkg_fwd_%02h", x), SBOX_FWD[x], m_fwd[x]);
      chk($sformatf("pkg_inv_%02h", x), SBOX_INV[x], m_inv[x]);
    end

    vt[0] = '{0, VEC_P, 1'b0, VEC_S, 16};
    vt[1] = '{1, VEC_P, 1'b0, VEC_S, 4};
    vt[2] = '{2, VEC_P, 1'b0, VEC_S, 1};
    vt[3] = '{1, VEC_S, 1'b1, inv_en ? VEC_P : model_word(VEC_S, 1'b0), 4};
    vt[4] = '{2, VEC_S, 1'b1, inv_en ? VEC_P : model_word(VEC_S, 1'b0), 1};
    foreach (vt[i]) begin
      run(vt[i].idx, vt[i].d, vt[i].inv, lat, res);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_data", i), res, vt[i].exp);
    end

    // Backpressure for 5 cycles in DONE, then a back-to-back accept.
    @(negedge clk);
    d_i[1] = VEC_P; inv_i[1] = 1'b0; v_i[1] = 1'b1; rdy_i[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v_i[1] = 1'b0;
    wait_valid(1, lat);
    chk("bp_latency", lat, 4);
    held = d_o[1];
    chk("bp_data", held, VEC_S);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", v_o[1], 1);
      chk("bp_hold", d_o[1], held);
      chk("bp_ready_low", rdy_o[1], 0);
    end
    w = {$urandom, $urandom, $urandom, $urandom};
    d_i[1] = w; inv_i[1] = 1'b0; v_i[1] = 1'b1; rdy_i[1] = 1'b1;
    #1;
    chk("b2b_ready", rdy_o[1], 1);
    @(posedge clk);
    @(negedge clk);
    v_i[1] = 1'b0;
    chk("b2b_busy", busy_o[1], 1);
    chk("b2b_valid_low", v_o[1], 0);
    chk("b2b_hold_prev", d_o[1], VEC_S);
    wait_valid(1, lat);
    chk("b2b_latency", lat, 4);
    chk("b2b_data", d_o[1], model_word(w, 1'b0));

    // Reset while the engine is on chunk 2.
    @(negedge clk);
    d_i[1] = {$urandom, $urandom, $urandom, $urandom}; inv_i[1] = 1'b0; v_i[1] = 1'b1; rdy_i[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_i[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_pre_busy", busy_o[1], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", v_o[1], 0);
    chk("rst_mid_data", d_o[1], 0);
    chk("rst_mid_busy", busy_o[1], 0);
    chk("rst_mid_ready", rdy_o[1], 1);
    @(negedge clk);
    rst_n = 1'b1;
    w = {$urandom, $urandom, $urandom, $urandom};
    run(1, w, 1'b0, lat, res);
    chk("rst_after_latency", lat, 4);
    chk("rst_after_data", res, model_word(w, 1'b0));

    // All 256 byte values across 16 words, both modes, plus forward-then-inverse round trip.
    for (int wi = 0; wi < 16; wi++) begin
      int idx = wi % 3;
      for (int n = 0; n < 16; n++) w[8*n +: 8] = 8'(16 * wi + n);
      run(idx, w, 1'b0, lat, res);
      chk($sformatf("sweep%0d_fwd", wi), res, model_word(w, 1'b0));
      chk($sformatf("sweep%0d_lat", wi), lat, lat_of[idx]);
      run(idx, res, 1'b1, lat, res2);
      chk($sformatf("sweep%0d_round", wi), res2, inv_en ? w : model_word(res, 1'b0));
      run(idx, w, 1'b1, lat, res);
      chk($sformatf("sweep%0d_inv", wi), res, model_word(w, 1'b1));
    end

    for (int r = 0; r < 20; r++) begin
      int   idx = int'($urandom_range(2, 0));
      logic inv = 1'($urandom);
      w = {$urandom, $urandom, $urandom, $urandom};
      run(idx, w, inv, lat, res);
      chk($sformatf("rand%0d_data", r), res, model_word(w, inv));
      chk($sformatf("rand%0d_lat", r), lat, lat_of[idx]);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
